// File: rtl/taiko_pkg.sv
// Shared constants and encodings for the taiko note datapath: note types,
// chart word layout, slot state encoding and the spawner FSM states.
package taiko_pkg;

    localparam int NUM_SLOTS = 15;
    localparam int TYPE_W    = 2;
    localparam int DELAY_W   = 8;
    localparam int CHART_W   = DELAY_W + TYPE_W;

    localparam logic [TYPE_W-1:0] NOTE_END = 2'b00;
    localparam logic [TYPE_W-1:0] NOTE_DON = 2'b01;
    localparam logic [TYPE_W-1:0] NOTE_KA  = 2'b10;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'b00,
        SLOT_MOVE = 2'b01,
        SLOT_HIT  = 2'b10,
        SLOT_MISS = 2'b11
    } slot_state_t;

    typedef enum logic [2:0] {
        SP_IDLE,
        SP_FETCH,
        SP_LATCH,
        SP_COUNT,
        SP_SPAWN,
        SP_DONE
    } spawn_state_t;

    // The reserved code 11 plays as a DON note.
    function automatic logic [TYPE_W-1:0] norm_type(input logic [TYPE_W-1:0] t);
        return (t == 2'b11) ? NOTE_DON : t;
    endfunction

endpackage

// File: rtl/note_spawner_rr_pick.sv
// Combinational round-robin finder: first set bit of req at or after ptr,
// wrapping modulo NUM_SLOTS.
module rr_pick #(
    parameter int NUM_SLOTS = 15,
    parameter int PTR_W     = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic                 found,
    output logic [PTR_W-1:0]     idx
);

    logic [PTR_W:0] w_pos;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        w_pos = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_pos = {1'b0, ptr} + (PTR_W+1)'(i);
            if (w_pos >= (PTR_W+1)'(NUM_SLOTS))
                w_pos = w_pos - (PTR_W+1)'(NUM_SLOTS);
            if (!found && req[w_pos[PTR_W-1:0]]) begin
                found = 1'b1;
                idx   = w_pos[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/note_spawner.sv
// Beat-chart player: walks a synchronous chart ROM, waits out each entry's
// delay in 64 Hz ticks, then pulses start on a free note slot chosen round-robin.
module note_spawner #(
    parameter int NUM_SLOTS   = taiko_pkg::NUM_SLOTS,
    parameter int ADDR_W      = 6,
    parameter int CHART_DEPTH = 64,
    parameter int DELAY_W     = taiko_pkg::DELAY_W
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   tick_64hz,
    input  logic                   run,
    input  logic [NUM_SLOTS-1:0]   slot_idle,
    output logic [ADDR_W-1:0]      chart_addr,
    input  logic [DELAY_W+1:0]     chart_data,
    output logic [NUM_SLOTS-1:0]   start,
    output logic [2*NUM_SLOTS-1:0] slot_type,
    output logic                   done,
    output logic [7:0]             dropped
);

    import taiko_pkg::*;

    localparam int PTR_W = $clog2(NUM_SLOTS);

    spawn_state_t           r_state;
    spawn_state_t           w_next;
    logic [ADDR_W-1:0]      r_addr;
    logic [DELAY_W-1:0]     r_cnt;
    logic [1:0]             r_type;
    logic [PTR_W-1:0]       r_ptr;
    logic [NUM_SLOTS-1:0]   r_start;
    logic [2*NUM_SLOTS-1:0] r_slot_type;
    logic [7:0]             r_dropped;

    logic [DELAY_W-1:0]     w_rom_delay;
    logic [1:0]             w_rom_type;
    logic                   w_abort;
    logic                   w_last;
    logic                   w_found;
    logic [PTR_W-1:0]       w_idx;
    logic [PTR_W-1:0]       w_ptr_next;
    logic [NUM_SLOTS-1:0]   w_onehot;

    assign w_rom_delay = chart_data[DELAY_W+1:2];
    assign w_rom_type  = chart_data[1:0];
    assign w_abort     = !run && (r_state != SP_IDLE);
    assign w_last      = (r_addr == ADDR_W'(CHART_DEPTH-1));
    assign w_ptr_next  = (w_idx == PTR_W'(NUM_SLOTS-1)) ? '0 : w_idx + 1'b1;
    assign w_onehot    = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << w_idx;

    rr_pick #(
        .NUM_SLOTS (NUM_SLOTS),
        .PTR_W     (PTR_W)
    ) u_pick (
        .req   (slot_idle),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            SP_IDLE:  if (run) w_next = SP_FETCH;
            SP_FETCH: w_next = SP_LATCH;
            SP_LATCH: begin
                if (w_rom_type == NOTE_END)
                    w_next = SP_DONE;
                else if (w_rom_delay == '0)
                    w_next = SP_SPAWN;
                else
                    w_next = SP_COUNT;
            end
            SP_COUNT: if (tick_64hz && (r_cnt == DELAY_W'(1))) w_next = SP_SPAWN;
            SP_SPAWN: w_next = w_last ? SP_DONE : SP_FETCH;
            SP_DONE:  w_next = SP_DONE;
            default:  w_next = SP_IDLE;
        endcase
        // Dropping run rewinds from anywhere, overriding every other transition.
        if (w_abort)
            w_next = SP_IDLE;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            r_state <= SP_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_addr      <= '0;
            r_cnt       <= '0;
            r_type      <= NOTE_END;
            r_ptr       <= '0;
            r_start     <= '0;
            r_slot_type <= '0;
            r_dropped   <= '0;
        end else begin
            r_start <= '0;
            if (w_abort) begin
                r_addr <= '0;
            end else begin
                case (r_state)
                    SP_IDLE: begin
                        if (run) begin
                            r_addr    <= '0;
                            r_dropped <= '0;
                        end
                    end
                    SP_LATCH: begin
                        r_type <= norm_type(w_rom_type);
                        r_cnt  <= w_rom_delay;
                    end
                    SP_COUNT: begin
                        if (tick_64hz)
                            r_cnt <= r_cnt - 1'b1;
                    end
                    SP_SPAWN: begin
                        if (w_found) begin
                            r_start <= w_onehot;
                            r_ptr   <= w_ptr_next;
                            for (int k = 0; k < NUM_SLOTS; k++)
                                if (w_idx == PTR_W'(k))
                                    r_slot_type[2*k +: 2] <= r_type;
                        end else if (r_dropped != 8'hFF) begin
                            r_dropped <= r_dropped + 1'b1;
                        end
                        if (!w_last)
                            r_addr <= r_addr + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign chart_addr = r_addr;
    assign start      = r_start;
    assign slot_type  = r_slot_type;
    assign dropped    = r_dropped;
    assign done       = (r_state == SP_DONE);

endmodule

// File: doc/note_spawner.md
Name: note_spawner

Overview:
- Upstream feeder for the 15 moving-note slots.
- Plays back a beat chart stored in a synchronous ROM. Each chart entry holds a delay, counted in 64 Hz ticks, and a note type.
- When an entry's delay expires, the block issues a one-cycle start pulse to a free note slot, chosen round-robin, and records the note type for that slot.
- Its start outputs replace the switch-driven started inputs of the note slots. The slot-idle status it consumes comes from each slot's current-state output.

Parameters:
- NUM_SLOTS, 15, number of note slots driven.
- ADDR_W, 6, chart ROM address width.
- CHART_DEPTH, 64, number of chart entries, at most 2^ADDR_W.
- DELAY_W, 8, width of the per-entry delay field.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick_64hz  in  1  one-cycle enable pulse from the 64 Hz counter.
- run  in  1  level; 1 = play the chart; 0 = abort and rewind.
- slot_idle  in  NUM_SLOTS  bit k = 1 when slot k is in its idle state.
- chart_addr  out  ADDR_W  ROM address.
- chart_data  in  DELAY_W+2  ROM word, valid 1 cycle after chart_addr. Layout is {delay[DELAY_W-1:0], type[1:0]}.
- start  out  NUM_SLOTS  one-hot, one-cycle spawn pulse.
- slot_type  out  2*NUM_SLOTS  registered note type per slot; slot k uses bits [2k+1:2k].
- done  out  1  chart finished.
- dropped  out  8  saturating count of spawns lost because no slot was free.

Behaviour:
- Note types:
  - 00 = END marker.
  - 01 = DON (red).
  - 10 = KA (blue).
  - 11 = reserved; treated as DON.
- Reset values: state IDLE, chart_addr 0, start 0, slot_type all 0, done 0, dropped 0, rr_ptr 0, delay counter 0.
- States: IDLE, FETCH, LATCH, COUNT, SPAWN, DONE.
- IDLE:
  - With run=1: clear dropped, set chart_addr=0, go to FETCH.
  - Otherwise stay.
- FETCH: drive chart_addr for one cycle, then go to LATCH (ROM latency is exactly 1).
- LATCH: capture delay and type from chart_data.
  - type=00: go to DONE.
  - delay=0: go to SPAWN.
  - Otherwise load the counter with delay and go to COUNT.
- COUNT:
  - Decrement only on cycles with tick_64hz=1 while in COUNT. A tick arriving in the LATCH cycle is not counted.
  - On the tick that takes the counter to 0, go to SPAWN on the next cycle.
  - An entry with delay D therefore spawns exactly D ticks after LATCH.
- SPAWN (one cycle):
  - Sample slot_idle and search for the first idle slot starting at rr_ptr, wrapping modulo NUM_SLOTS.
  - If slot k is found: start[k]=1 in the following cycle only, slot_type[k]=captured type, rr_ptr=(k+1) mod NUM_SLOTS.
  - If no slot is free: no pulse, and dropped increments, saturating at 255.
  - Then: if chart_addr==CHART_DEPTH-1, go to DONE; otherwise increment chart_addr and go to FETCH.
- DONE:
  - done=1, start=0.
  - Stay until run=0, then go to IDLE with chart_addr=0 and done=0.
- run=0 in any state other than IDLE:
  - Next state is IDLE, chart_addr=0, done=0.
  - No start pulse is issued on the abort cycle or afterwards.
  - slot_type and dropped hold their values.
- start is registered, so at most one bit is high in any cycle and never for two consecutive cycles.
- Minimum spacing between two spawns is 3 cycles (FETCH, LATCH, SPAWN).
- slot_type[k] changes only in the same cycle that start[k] rises. Other slots' types are untouched.
- reset asserted mid-chart returns everything to the reset values on the next edge, regardless of run.

Decomposition:
- Shared package taiko_pkg:
  - NOTE_END, NOTE_DON, NOTE_KA constants.
  - NUM_SLOTS.
  - Chart word field widths.
  - Slot-idle state encoding, also used by the note-slot and counter modules.
- Sub-module rr_pick: combinational round-robin finder.
  - Inputs: req[NUM_SLOTS], ptr.
  - Outputs: found, idx.
  - Instantiated once, in the SPAWN path.

Test Plan:
- Chart {delay 3, DON},{delay 0, KA},{END}; all slots idle; run=1 → start[0] pulses 3 ticks after the first LATCH; start[1] pulses 3 cycles later; slot_type[1:0]=01, slot_type[3:2]=10; done=1 after END.
- 16 entries with delay 1, all slots idle → start bits fire in order 0..14, then start[0] again (wrap); rr_ptr=1 afterwards.
- slot_idle=0 for all slots over 2 spawns → no start pulses, dropped=2; chart continues to the next entry.
- slot_idle=15'b000_0000_0010_0000 with rr_ptr=7 → start[5] pulses (wrap search); rr_ptr=6.
- run dropped to 0 during COUNT with 2 ticks remaining → no pulse; state IDLE, chart_addr=0 next cycle; run=1 again restarts from entry 0.
- 64 non-END entries (CHART_DEPTH reached) → done asserts after the 64th SPAWN with chart_addr=63 and no 65th fetch; reset mid-chart → all outputs return to reset values on the next edge.
